// File: rtl/pwm_pkg.sv
// pwm_pkg: shared definitions for the PWM driver.
//   - pwm_state_e : output FSM state encoding (IDLE/HIGH/LOW/DEAD)
//   - CTRL_*      : bit positions inside cfg_ctrl
//   - STAT_*      : bit positions inside status
//   - gate_drive  : maps an FSM state plus invert to the {pwm_h, pwm_l} levels
package pwm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_DEAD = 2'd3
    } pwm_state_e;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_INV  = 1;
    localparam int CTRL_FOFF = 2;

    localparam int STAT_RUN  = 0;
    localparam int STAT_PEND = 1;
    localparam int STAT_CLIP = 2;
    localparam int STAT_PINV = 3;

    // A period shorter than this cannot produce a meaningful waveform.
    localparam int MIN_PERIOD = 2;

    // Each side is active only in its own state; invert flips the idle level
    // so that "inactive" stays consistent for both drives.
    function automatic logic [1:0] gate_drive(input pwm_state_e st, input logic inv);
        return {(st == ST_HIGH) ^ inv, (st == ST_LOW) ^ inv};
    endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: output FSM with dead-time insertion.
//   clk, rstb  : clock, synchronous active-high reset (outputs forced to 0)
//   i_run      : counter is running with a valid period; low forces IDLE
//   i_raw      : raw PWM level from the period counter
//   i_inv      : output polarity invert
//   i_deadtime : dead-time length in clk cycles (0 = direct switch-over)
//   o_pwm_h    : registered high-side drive
//   o_pwm_l    : registered low-side drive
//   o_running  : FSM is outside IDLE
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int DT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                i_run,
    input  logic                i_raw,
    input  logic                i_inv,
    input  logic [DT_WIDTH-1:0] i_deadtime,
    output logic                o_pwm_h,
    output logic                o_pwm_l,
    output logic                o_running
);

    pwm_state_e          r_state;
    logic [DT_WIDTH-1:0] r_dt_cnt;
    logic                r_pwm_h;
    logic                r_pwm_l;
    pwm_state_e          w_side;

    assign w_side = i_raw ? ST_HIGH : ST_LOW;

    // Outputs are registered from the state being entered, so they line up
    // with r_state and trail the raw level by exactly one cycle.
    always_ff @(posedge clk) begin
        if (rstb) begin
            r_state  <= ST_IDLE;
            r_dt_cnt <= '0;
            r_pwm_h  <= 1'b0;
            r_pwm_l  <= 1'b0;
        end else if (!i_run) begin
            r_state            <= ST_IDLE;
            r_dt_cnt           <= '0;
            {r_pwm_h, r_pwm_l} <= gate_drive(ST_IDLE, i_inv);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state            <= w_side;
                    {r_pwm_h, r_pwm_l} <= gate_drive(w_side, i_inv);
                end
                ST_HIGH, ST_LOW: begin
                    if (w_side == r_state) begin
                        {r_pwm_h, r_pwm_l} <= gate_drive(r_state, i_inv);
                    end else if (i_deadtime == '0) begin
                        r_state            <= w_side;
                        {r_pwm_h, r_pwm_l} <= gate_drive(w_side, i_inv);
                    end else begin
                        // Count loads with deadtime-1 so DEAD lasts exactly deadtime cycles.
                        r_state            <= ST_DEAD;
                        r_dt_cnt           <= i_deadtime - DT_WIDTH'(1);
                        {r_pwm_h, r_pwm_l} <= gate_drive(ST_DEAD, i_inv);
                    end
                end
                ST_DEAD: begin
                    if (r_dt_cnt == '0) begin
                        r_state            <= w_side;
                        {r_pwm_h, r_pwm_l} <= gate_drive(w_side, i_inv);
                    end else begin
                        r_dt_cnt           <= r_dt_cnt - DT_WIDTH'(1);
                        {r_pwm_h, r_pwm_l} <= gate_drive(ST_DEAD, i_inv);
                    end
                end
                default: begin
                    r_state            <= ST_IDLE;
                    {r_pwm_h, r_pwm_l} <= gate_drive(ST_IDLE, i_inv);
                end
            endcase
        end
    end

    assign o_pwm_h   = r_pwm_h;
    assign o_pwm_l   = r_pwm_l;
    assign o_running = (r_state != ST_IDLE);

endmodule

// File: rtl/pwm_driver.sv
// pwm_driver: complementary PWM generator with shadowed configuration.
//   clk, rstb     : clock, synchronous active-high reset
//   cfg_ctrl      : bit0 enable, bit1 invert, bit2 force-off (others ignored)
//   cfg_period    : period in clk cycles (values < 2 are invalid)
//   cfg_duty      : high-side on-count in clk cycles
//   cfg_deadtime  : dead-time in clk cycles
//   cfg_update    : one-cycle strobe, shadow-loads period/duty/deadtime
//   pwm_h, pwm_l  : registered gate drives
//   period_pulse  : high in the last cycle of each period
//   status        : bit0 running, bit1 update pending, bit2 duty clipped,
//                   bit3 period invalid
module pwm_driver
    import pwm_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DT_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic [DATA_WIDTH-1:0] cfg_ctrl,
    input  logic [DATA_WIDTH-1:0] cfg_period,
    input  logic [DATA_WIDTH-1:0] cfg_duty,
    input  logic [DT_WIDTH-1:0]   cfg_deadtime,
    input  logic                  cfg_update,
    output logic                  pwm_h,
    output logic                  pwm_l,
    output logic                  period_pulse,
    output logic [DATA_WIDTH-1:0] status
);

    logic [DATA_WIDTH-1:0] r_cnt;
    logic [DATA_WIDTH-1:0] r_period;
    logic [DATA_WIDTH-1:0] r_duty;
    logic [DT_WIDTH-1:0]   r_dt;
    logic [DATA_WIDTH-1:0] r_period_sh;
    logic [DATA_WIDTH-1:0] r_duty_sh;
    logic [DT_WIDTH-1:0]   r_dt_sh;
    logic                  r_pending;
    logic                  r_run;
    logic                  r_en_q;

    logic w_en;
    logic w_inv;
    logic w_act;
    logic w_en_rise;
    logic w_pvalid;
    logic w_counting;
    logic w_wrap;
    logic w_clip;
    logic w_raw;
    logic w_load_slot;
    logic w_running;
    logic w_unused_ctrl;

    assign w_en          = cfg_ctrl[CTRL_EN];
    assign w_inv         = cfg_ctrl[CTRL_INV];
    assign w_act         = w_en & ~cfg_ctrl[CTRL_FOFF];
    assign w_en_rise     = w_en & ~r_en_q;
    assign w_unused_ctrl = ^cfg_ctrl[DATA_WIDTH-1:3];

    // r_run means "was active last cycle": the first active cycle only loads
    // and parks the counter at 0, counting starts the cycle after.
    assign w_pvalid    = (r_period >= DATA_WIDTH'(MIN_PERIOD));
    assign w_counting  = r_run & w_pvalid;
    assign w_wrap      = w_counting & (r_cnt == r_period - DATA_WIDTH'(1));
    assign w_clip      = (r_duty >= r_period);
    assign w_raw       = w_clip | (r_cnt < r_duty);
    // While stalled on an invalid period there is no wrap to wait for, so
    // every cycle acts as a load point; otherwise a bad period would stick.
    assign w_load_slot = w_wrap | (r_run & ~w_pvalid);

    always_ff @(posedge clk) begin
        if (rstb) begin
            r_cnt       <= '0;
            r_period    <= '0;
            r_duty      <= '0;
            r_dt        <= '0;
            r_period_sh <= '0;
            r_duty_sh   <= '0;
            r_dt_sh     <= '0;
            r_pending   <= 1'b0;
            r_run       <= 1'b0;
            r_en_q      <= 1'b0;
        end else begin
            r_en_q <= w_en;
            r_run  <= w_act;
            if (w_en_rise) begin
                r_period  <= cfg_period;
                r_duty    <= cfg_duty;
                r_dt      <= cfg_deadtime;
                r_pending <= 1'b0;
                r_cnt     <= '0;
            end else if (!w_act) begin
                r_pending <= 1'b0;
                r_cnt     <= '0;
            end else begin
                r_cnt <= (w_counting && !w_wrap) ? r_cnt + DATA_WIDTH'(1) : '0;
                if (w_load_slot) begin
                    // A strobe landing on the load point bypasses the shadow.
                    if (cfg_update) begin
                        r_period <= cfg_period;
                        r_duty   <= cfg_duty;
                        r_dt     <= cfg_deadtime;
                    end else if (r_pending) begin
                        r_period <= r_period_sh;
                        r_duty   <= r_duty_sh;
                        r_dt     <= r_dt_sh;
                    end
                    r_pending <= 1'b0;
                end else if (cfg_update) begin
                    r_period_sh <= cfg_period;
                    r_duty_sh   <= cfg_duty;
                    r_dt_sh     <= cfg_deadtime;
                    r_pending   <= 1'b1;
                end
            end
        end
    end

    pwm_deadtime #(
        .DT_WIDTH(DT_WIDTH)
    ) u_deadtime (
        .clk       (clk),
        .rstb      (rstb),
        .i_run     (w_act & w_counting),
        .i_raw     (w_raw),
        .i_inv     (w_inv),
        .i_deadtime(r_dt),
        .o_pwm_h   (pwm_h),
        .o_pwm_l   (pwm_l),
        .o_running (w_running)
    );

    assign period_pulse = w_wrap;

    always_comb begin
        status            = '0;
        status[STAT_RUN]  = w_running;
        status[STAT_PEND] = r_pending;
        status[STAT_CLIP] = r_run & w_clip;
        status[STAT_PINV] = r_run & ~w_pvalid;
    end

endmodule

// File: tb/tb_pwm_driver.sv
module tb_pwm_driver;

    localparam int DW = 16;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rstb;
    logic [DW-1:0] cfg_ctrl;
    logic [DW-1:0] cfg_period;
    logic [DW-1:0] cfg_duty;
    logic [TW-1:0] cfg_deadtime;
    logic          cfg_update;
    logic          pwm_h;
    logic          pwm_l;
    logic          period_pulse;
    logic [DW-1:0] status;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pwm_driver #(.DATA_WIDTH(DW), .DT_WIDTH(TW)) dut (
        .clk         (clk),
        .rstb        (rstb),
        .cfg_ctrl    (cfg_ctrl),
        .cfg_period  (cfg_period),
        .cfg_duty    (cfg_duty),
        .cfg_deadtime(cfg_deadtime),
        .cfg_update  (cfg_update),
        .pwm_h       (pwm_h),
        .pwm_l       (pwm_l),
        .period_pulse(period_pulse),
        .status      (status)
    );

    // ---------------- reference model ----------------
    // Time-stamp view: the counter value is (cycle - period start cycle);
    // dead-time ends at an absolute cycle number.
    int cyc = 0;
    bit m_live = 0;
    int mP = 0, mD = 0, mT = 0, sP = 0, sD = 0, sT = 0;
    bit m_pend = 0, m_run = 0, m_enq = 0;
    int m_start = 0;
    int m_side = 0;              // 0 idle, 1 high, 2 low, 3 dead
    int m_dead_end = 0;
    bit m_h = 0, m_l = 0;

    function automatic bit m_counting();
        return m_run && (mP >= 2);
    endfunction

    always @(posedge clk) begin
        bit act, counting, wrap, raw, go;
        int want;
        act      = cfg_ctrl[0] && !cfg_ctrl[2];
        counting = m_counting();
        wrap     = counting && (cyc - m_start == mP - 1);
        raw      = (mD >= mP) || (cyc - m_start < mD);
        want     = raw ? 1 : 2;
        if (rstb) begin
            m_live = 1; mP = 0; mD = 0; mT = 0; sP = 0; sD = 0; sT = 0;
            m_pend = 0; m_run = 0; m_enq = 0; m_side = 0; m_h = 0; m_l = 0;
            m_start = cyc + 1;
        end else begin
            go = act && counting;
            if (!go) m_side = 0;
            else if (m_side == 0) m_side = want;
            else if (m_side == 3) begin
                if (cyc == m_dead_end) m_side = want;
            end else if (m_side != want) begin
                if (mT == 0) m_side = want;
                else begin m_side = 3; m_dead_end = cyc + mT; end
            end
            m_h = (m_side == 1) ^ cfg_ctrl[1];
            m_l = (m_side == 2) ^ cfg_ctrl[1];
            if (cfg_ctrl[0] && !m_enq) begin
                mP = cfg_period; mD = cfg_duty; mT = cfg_deadtime;
                m_pend = 0; m_start = cyc + 1;
            end else if (!act) begin
                m_pend = 0; m_start = cyc + 1;
            end else begin
                if (!counting || wrap) m_start = cyc + 1;
                if (wrap || (m_run && mP < 2)) begin
                    if (cfg_update) begin mP = cfg_period; mD = cfg_duty; mT = cfg_deadtime; end
                    else if (m_pend) begin mP = sP; mD = sD; mT = sT; end
                    m_pend = 0;
                end else if (cfg_update) begin
                    sP = cfg_period; sD = cfg_duty; sT = cfg_deadtime; m_pend = 1;
                end
            end
            m_run = act;
            m_enq = cfg_ctrl[0];
        end
        cyc++;
    end

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [DW-1:0] e_stat;
        bit e_pulse;
        if (m_live) begin
            e_pulse = m_counting() && (cyc - m_start == mP - 1);
            e_stat = '0;
            e_stat[0] = (m_side != 0);
            e_stat[1] = m_pend;
            e_stat[2] = m_run && (mD >= mP);
            e_stat[3] = m_run && (mP < 2);
            chk("model.pwm_h", DW'(pwm_h), DW'(m_h));
            chk("model.pwm_l", DW'(pwm_l), DW'(m_l));
            chk("model.period_pulse", DW'(period_pulse), DW'(e_pulse));
            chk("model.status", status, e_stat);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic observe(input int n, output int nh, output int nl,
                           output int nboth, output int np, output int nover);
        nh = 0; nl = 0; nboth = 0; np = 0; nover = 0;
        repeat (n) begin
            @(negedge clk);
            if (pwm_h) nh++;
            if (pwm_l) nl++;
            if (!pwm_h && !pwm_l) nboth++;
            if (pwm_h && pwm_l) nover++;
            if (period_pulse) np++;
        end
    endtask

    task automatic wait_pulse(input string nm, output int n);
        bit done;
        n = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            if (period_pulse) done = 1;
            else begin
                n++;
                if (n > 40) begin
                    total++; bad++;
                    $display("FAIL %s no period_pulse within 40 cycles", nm);
                    done = 1;
                end
            end
        end
    endtask

    initial begin
        int nh, nl, nb, np, no, n;
        rstb = 1'b1; cfg_ctrl = '0; cfg_period = '0; cfg_duty = '0;
        cfg_deadtime = '0; cfg_update = 1'b0;
        step(3);
        chk("reset.pwm_h", DW'(pwm_h), 0);
        chk("reset.pwm_l", DW'(pwm_l), 0);
        chk("reset.status", status, 0);

        // period 10, duty 3, no dead-time
        rstb = 1'b0; cfg_period = 10; cfg_duty = 3; cfg_deadtime = 0; cfg_ctrl = 1;
        step(12);
        observe(20, nh, nl, nb, np, no);
        chk("d3.high_cycles", DW'(nh), 6);
        chk("d3.low_cycles", DW'(nl), 14);
        chk("d3.pulses", DW'(np), 2);
        chk("d3.overlap", DW'(no), 0);

        // period 10, duty 5, dead-time 2
        cfg_ctrl = 0; step(2);
        cfg_duty = 5; cfg_deadtime = 2; cfg_ctrl = 1;
        step(15);
        observe(20, nh, nl, nb, np, no);
        chk("dt2.high_cycles", DW'(nh), 6);
        chk("dt2.low_cycles", DW'(nl), 6);
        chk("dt2.both_low", DW'(nb), 8);
        chk("dt2.overlap", DW'(no), 0);

        // shadow update of duty at counter 4
        cfg_ctrl = 0; step(2);
        cfg_duty = 3; cfg_deadtime = 0; cfg_ctrl = 1;
        step(3);
        wait_pulse("upd.sync", n);
        step(1);
        step(4);
        cfg_duty = 8; cfg_update = 1'b1;
        step(1);
        cfg_update = 1'b0;
        chk("upd.pending", DW'(status[1]), 1);
        observe(15, nh, nl, nb, np, no);
        chk("upd.high_cycles", DW'(nh), 8);

        // duty beyond period, then invalid period, then recovery
        cfg_duty = 12; cfg_update = 1'b1; step(1); cfg_update = 1'b0;
        step(25);
        chk("clip.status2", DW'(status[2]), 1);
        observe(20, nh, nl, nb, np, no);
        chk("clip.high_cycles", DW'(nh), 20);
        chk("clip.low_cycles", DW'(nl), 0);
        step(1);
        cfg_period = 1; cfg_duty = 0; cfg_update = 1'b1; step(1); cfg_update = 1'b0;
        step(15);
        chk("pinv.status3", DW'(status[3]), 1);
        chk("pinv.running", DW'(status[0]), 0);
        observe(12, nh, nl, nb, np, no);
        chk("pinv.pulses", DW'(np), 0);
        chk("pinv.high_cycles", DW'(nh), 0);
        step(1);
        cfg_period = 10; cfg_duty = 3; cfg_update = 1'b1; step(1); cfg_update = 1'b0;
        step(3);

        // reset in the middle of dead-time with invert
        cfg_ctrl = 0; step(2);
        cfg_period = 10; cfg_duty = 5; cfg_deadtime = 2; cfg_ctrl = 3;
        step(13);
        wait_pulse("rst.sync", n);
        step(1);
        step(1);
        chk("dead.running", DW'(status[0]), 1);
        chk("dead.inv_h", DW'(pwm_h), 1);
        chk("dead.inv_l", DW'(pwm_l), 1);
        rstb = 1'b1;
        step(1);
        chk("rst.pwm_h", DW'(pwm_h), 0);
        chk("rst.pwm_l", DW'(pwm_l), 0);
        chk("rst.status", status, 0);
        step(1);
        rstb = 1'b0;
        wait_pulse("rst.restart", n);
        chk("rst.first_pulse", DW'(n), 10);

        // update on the wrap cycle, then force-off mid-period
        wait_pulse("wrap.sync", n);
        cfg_period = 8; cfg_duty = 2; cfg_deadtime = 0; cfg_update = 1'b1;
        step(1);
        cfg_update = 1'b0;
        chk("wrap.pending", DW'(status[1]), 0);
        wait_pulse("wrap.newperiod", n);
        chk("wrap.period8", DW'(n), 7);
        step(1);
        step(2);
        cfg_duty = 4; cfg_update = 1'b1;
        step(1);
        cfg_update = 1'b0; cfg_ctrl = 7;
        chk("foff.pending_before", DW'(status[1]), 1);
        step(1);
        chk("foff.inv_h", DW'(pwm_h), 1);
        chk("foff.inv_l", DW'(pwm_l), 1);
        chk("foff.status", status, 0);

        cfg_ctrl = 0;
        step(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_driver.md
PWM_DRIVER -- requirements
Module: pwm_driver

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the width of the period, duty and status words.
REQ-002 Parameter DT_WIDTH, default 8, SHALL set the width of the dead-time count.
REQ-003 clk  input  1  SHALL be the single clock; all logic on rising edge.
REQ-004 rstb  input  1  SHALL be a synchronous, active-high reset.
REQ-005 cfg_ctrl  input  DATA_WIDTH  SHALL carry control bits: bit0 enable, bit1 output invert, bit2 force-off; other bits ignored.
REQ-006 cfg_period  input  DATA_WIDTH  SHALL give the PWM period in clk cycles.
REQ-007 cfg_duty  input  DATA_WIDTH  SHALL give the high-side on-count in clk cycles.
REQ-008 cfg_deadtime  input  DT_WIDTH  SHALL give the dead-time in clk cycles.
REQ-009 cfg_update  input  1  SHALL be a one-cycle strobe requesting a shadow load of period, duty and deadtime.
REQ-010 pwm_h, pwm_l  output  1 each  SHALL be the registered complementary high-side and low-side gate drives.
REQ-011 period_pulse  output  1  SHALL pulse for one cycle on every counter wrap.
REQ-012 status  output  DATA_WIDTH  SHALL report bit0 running, bit1 update pending, bit2 duty clipped, bit3 period invalid; others 0.

Function
REQ-013 Counter SHALL count 0..period_act-1 and wrap to 0; period_pulse SHALL be 1 in the cycle the counter equals period_act-1.
REQ-014 Raw PWM SHALL be (counter < duty_act); if duty_act >= period_act, raw SHALL be constantly 1 and status bit2 SHALL be 1.
REQ-015 A cfg_update strobe SHALL capture cfg_period, cfg_duty and cfg_deadtime into shadow registers and set pending.
REQ-016 Shadow values SHALL move to the active registers only at wrap; pending SHALL clear in that cycle.
REQ-017 cfg_update coinciding with a wrap SHALL load the strobed values directly into the active registers, leaving pending clear.
REQ-018 A second cfg_update before wrap SHALL overwrite the shadow registers; last write wins.
REQ-019 Output FSM states SHALL be IDLE, HIGH, LOW and DEAD.
REQ-020 IDLE->HIGH or IDLE->LOW per raw SHALL occur on the cycle after enable=1 with period valid and force-off=0.
REQ-021 HIGH->DEAD or LOW->DEAD SHALL occur when raw differs from the current side.
REQ-022 DEAD SHALL hold both outputs low for exactly deadtime_act cycles, then enter the side given by raw at expiry.
REQ-023 With deadtime_act=0, transitions SHALL go directly HIGH<->LOW.
REQ-024 pwm_h SHALL be 1 only in HIGH and pwm_l only in LOW, each XOR invert; pwm_h and pwm_l SHALL never be simultaneously active.
REQ-025 Outputs SHALL follow raw with exactly one clk latency, excluding dead-time.
REQ-026 On enable rising edge, the counter SHALL restart at 0 with active registers loaded from the cfg inputs in the same cycle.
REQ-027 enable=0 or force-off=1 SHALL force IDLE on the next cycle, drive both outputs inactive, clear the counter and clear pending.
REQ-028 Active period < 2 SHALL set status bit3, hold IDLE and suppress period_pulse until a valid period loads.
REQ-029 status bit0 SHALL be 1 in every state except IDLE.

Reset
REQ-030 While rstb=1, the block SHALL enter IDLE and clear the counter, active and shadow registers, pending, period_pulse and status.
REQ-031 While rstb=1, pwm_h and pwm_l SHALL be 0 regardless of invert, and this SHALL take effect mid-period or mid-dead-time.

Structure
REQ-032 A shared package pwm_pkg SHALL hold the FSM state encoding and the cfg_ctrl and status bit-index constants.
REQ-033 A sub-module pwm_deadtime SHALL implement the FSM and dead-time counter; pwm_driver SHALL implement the counter, shadow logic and status.

Verification
REQ-034 Period 10, duty 3, deadtime 0, enable -> pwm_h high 3 / low 7 cycles, period_pulse every 10 cycles.
REQ-035 Period 10, duty 5, deadtime 2 -> each edge preceded by 2 cycles of both low; overlap never seen.
REQ-036 cfg_update duty 8 at counter 4 -> old duty finishes the period, new duty from next period; status bit1 high between strobe and wrap.
REQ-037 Duty 12 with period 10 -> pwm_h constantly 1, status bit2=1; period 1 -> IDLE, status bit3=1, no period_pulse.
REQ-038 rstb=1 during DEAD with invert=1 -> pwm_h=pwm_l=0 next cycle, status=0, counter 0 after release.
REQ-039 cfg_update on the wrap cycle, then force-off mid-period -> new values active immediately; outputs inactive next cycle and pending 0.
